// File: rtl/calc_disp_pkg.sv
// Shared types and helpers for the calculator display driver: digit codes,
// 7-segment encoding and the conversion FSM state type.
package calc_disp_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t D_BLANK = 4'hA;
    localparam digit_t D_E     = 4'hB;
    localparam digit_t D_R     = 4'hC;
    localparam digit_t D_DASH  = 4'hD;

    // Largest value that fits on five decimal digits
    localparam int unsigned MAX_DISP = 99999;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    // Segment order {a,b,c,d,e,f,g}, active-high
    function automatic logic [6:0] seg_encode(input digit_t d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            D_E:     s = 7'b1001111;
            D_R:     s = 7'b0000101;
            D_DASH:  s = 7'b0000001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/calc_bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, start/done handshake.
// The operand is latched on start; done pulses for one cycle in LOAD while the
// BCD result is stable on bcd.
module calc_bin2bcd_seq
    import calc_disp_pkg::*;
#(
    parameter int BIN_W  = 17,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      operand,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [4*DIGITS-1:0]  adj;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
        end
    end

    // Next state: add-3 on every nibble >=5, then shift {bcd,bin} left by one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        done    = 1'b0;
        adj     = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = operand;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj[4*DIGITS-2:0], bin_q, 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) state_d = LOAD;
            end
            LOAD: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/calc_display_driver.sv
// Calculator result display: snapshots value/err, converts changed values to
// BCD, loads error/overflow patterns directly, and scans a multiplexed
// 5-digit 7-segment display with leading-zero blanking.
module calc_display_driver
    import calc_disp_pkg::*;
#(
    parameter int BIN_W    = 17,
    parameter int DIGITS   = 5,
    parameter int SCAN_DIV = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  value,
    input  logic              err,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              busy,
    output logic              disp_valid
);

    localparam int SC_W  = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [BIN_W-1:0]          snap_v_q, snap_v_d;
    logic                      snap_e_q, snap_e_d;
    logic                      snap_ok_q, snap_ok_d;
    logic                      pending_q, pending_d;
    logic [DIGITS-1:0][3:0]    disp_q, disp_d;
    logic [SC_W-1:0]           scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    logic                      change;
    logic                      conv_start, conv_busy, conv_done;
    logic [4*DIGITS-1:0]       conv_bcd;
    logic                      lead;
    digit_t                    nib;

    calc_bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_bcd (
        .clk     (clk),
        .reset   (reset),
        .start   (conv_start),
        .operand (value),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    // Register file for snapshot, pending flag, display digits and scan position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_v_q   <= '0;
            snap_e_q   <= 1'b0;
            snap_ok_q  <= 1'b0;
            pending_q  <= 1'b1;
            disp_q     <= {DIGITS{D_BLANK}};
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            snap_v_q   <= snap_v_d;
            snap_e_q   <= snap_e_d;
            snap_ok_q  <= snap_ok_d;
            pending_q  <= pending_d;
            disp_q     <= disp_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
        end
    end

    // The snapshot is meaningless until the first clock after reset; the
    // reset-time pending flag covers that cycle instead.
    assign change = snap_ok_q && ((value != snap_v_q) || (err != snap_e_q));

    // Pending tracking, pattern selection and display register update
    always_comb begin
        snap_v_d   = value;
        snap_e_d   = err;
        snap_ok_d  = 1'b1;
        pending_d  = pending_q;
        disp_d     = disp_q;
        conv_start = 1'b0;
        lead       = 1'b1;
        nib        = D_BLANK;
        if (!conv_busy && pending_q) begin
            pending_d = 1'b0;
            if (err) begin
                for (int i = 0; i < DIGITS; i++) disp_d[i] = D_BLANK;
                disp_d[DIGITS-1] = D_E;
                disp_d[DIGITS-2] = D_R;
                disp_d[DIGITS-3] = D_R;
            end else if (32'(value) > MAX_DISP) begin
                for (int i = 0; i < DIGITS; i++) disp_d[i] = D_DASH;
            end else begin
                conv_start = 1'b1;
            end
        end
        if (conv_done) begin
            // Blank zeros above the most significant nonzero digit; digit 0 always shows
            for (int i = DIGITS - 1; i >= 0; i--) begin
                nib = conv_bcd[4*i +: 4];
                if (lead && (nib == 4'd0) && (i != 0)) begin
                    disp_d[i] = D_BLANK;
                end else begin
                    disp_d[i] = nib;
                    lead      = 1'b0;
                end
            end
        end
        // A new change always wins over the clear so the last value is shown
        if (change) pending_d = 1'b1;
    end

    // Multiplex scan: hold each digit for SCAN_DIV clocks
    always_comb begin
        scan_cnt_d = scan_cnt_q + SC_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign an         = DIGITS'(1) << idx_q;
    assign seg        = seg_encode(disp_q[idx_q]);
    assign busy       = conv_busy;
    assign disp_valid = !conv_busy && !pending_q && !change;

endmodule

// File: tb/tb_calc_display_driver.sv
// Directed bench for calc_display_driver with a fast scan (SCAN_DIV=4).
module tb_calc_display_driver;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                           S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                           S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                           S9 = 7'b1111011, SB = 7'b0000000, SE = 7'b1001111,
                           SR = 7'b0000101, SD = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] value;
    logic        err;
    logic [6:0]  seg;
    logic [4:0]  an;
    logic        busy;
    logic        disp_valid;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [16:0]     v;
        logic            e;
        logic            conv;
        logic [4:0][6:0] segs;
    } vec_t;

    vec_t vt[10];

    calc_display_driver #(.BIN_W(17), .DIGITS(5), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .err        (err),
        .seg        (seg),
        .an         (an),
        .busy       (busy),
        .disp_valid (disp_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm, output int cyc, output int bcyc);
        cyc  = 0;
        bcyc = 0;
        do begin
            tick();
            cyc++;
            if (busy) bcyc++;
        end while (!disp_valid && cyc < 60);
        if (!disp_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got disp_valid=0 want 1", nm);
        end
    endtask

    // Sweep one full scan round and capture the segments shown for each digit
    task automatic read_disp(output logic [4:0][6:0] got);
        got = 'x;
        for (int k = 0; k < 20; k++) begin
            for (int d = 0; d < 5; d++) if (an == 5'(1 << d)) got[d] = seg;
            tick();
        end
    endtask

    task automatic check_disp(input string nm, input logic [4:0][6:0] exp);
        logic [4:0][6:0] got;
        read_disp(got);
        for (int d = 0; d < 5; d++) chk($sformatf("%s dig%0d", nm, d), 32'(got[d]), 32'(exp[d]));
    endtask

    initial begin
        int cyc, bcyc, first;
        logic [4:0] cur;
        logic [4:0][6:0] e1000;

        vt[0] = '{17'd0,      1'b0, 1'b1, {SB, SB, SB, SB, S0}};
        vt[1] = '{17'd99999,  1'b0, 1'b1, {S9, S9, S9, S9, S9}};
        vt[2] = '{17'd100000, 1'b0, 1'b0, {SD, SD, SD, SD, SD}};
        vt[3] = '{17'd1250,   1'b1, 1'b0, {SE, SR, SR, SB, SB}};
        vt[4] = '{17'd1250,   1'b0, 1'b1, {SB, S1, S2, S5, S0}};
        vt[5] = '{17'd40030,  1'b0, 1'b1, {S4, S0, S0, S3, S0}};
        vt[6] = '{17'd7,      1'b0, 1'b1, {SB, SB, SB, SB, S7}};
        vt[7] = '{17'd10000,  1'b0, 1'b1, {S1, S0, S0, S0, S0}};
        vt[8] = '{17'd86,     1'b0, 1'b1, {SB, SB, SB, S8, S6}};
        vt[9] = '{17'd131071, 1'b0, 1'b0, {SD, SD, SD, SD, SD}};
        e1000 = {SB, S1, S0, S0, S0};

        // Reset state, then conversion of 1250 alongside the scan walk
        value = 17'd1250;
        err   = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst seg", 32'(seg), 32'(SB));
        chk("rst an", 32'(an), 32'h1);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst disp_valid", 32'(disp_valid), 32'h0);
        reset = 1'b0;
        cur   = 5'b00001;
        bcyc  = 0;
        first = 0;
        for (int s = 0; s < 24; s++) begin
            chk($sformatf("scan an s%0d", s), 32'(an), 32'(cur));
            tick();
            if (busy) bcyc++;
            if (disp_valid && first == 0) first = s + 1;
            if (s % 4 == 3) cur = (cur == 5'b10000) ? 5'b00001 : (cur << 1);
        end
        chk("t1 busy clocks", 32'(bcyc), 32'd18);
        chk("t1 valid by 20", 32'(first >= 1 && first <= 20), 32'h1);
        check_disp("t1 1250", {SB, S1, S2, S5, S0});

        // Table of steady-state values, patterns and boundaries
        for (int i = 0; i < 10; i++) begin
            value = vt[i].v;
            err   = vt[i].e;
            wait_valid($sformatf("vec%0d", i), cyc, bcyc);
            chk($sformatf("vec%0d latency", i), 32'(cyc), vt[i].conv ? 32'd20 : 32'd2);
            chk($sformatf("vec%0d busy", i), 32'(bcyc), vt[i].conv ? 32'd18 : 32'd0);
            check_disp($sformatf("vec%0d", i), vt[i].segs);
        end

        // Value change in the middle of a conversion
        value = 17'd1000;
        repeat (2) tick();
        repeat (5) tick();
        value = 17'd2000;
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("t5 first load done", 32'(busy), 32'h0);
        chk("t5 valid low", 32'(disp_valid), 32'h0);
        for (int d = 0; d < 5; d++) if (an == 5'(1 << d)) chk("t5 shows 1000", 32'(seg), 32'(e1000[d]));
        tick();
        chk("t5 busy again", 32'(busy), 32'h1);
        wait_valid("t5", cyc, bcyc);
        check_disp("t5 2000", {SB, S2, S0, S0, S0});

        // Reset pulse during SHIFT
        value = 17'd4321;
        repeat (2) tick();
        repeat (8) tick();
        #2 reset = 1'b1;
        #1;
        chk("t6 an", 32'(an), 32'h1);
        chk("t6 seg", 32'(seg), 32'(SB));
        chk("t6 busy", 32'(busy), 32'h0);
        chk("t6 disp_valid", 32'(disp_valid), 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        wait_valid("t6", cyc, bcyc);
        chk("t6 within 20", 32'(cyc <= 20), 32'h1);
        check_disp("t6 4321", {SB, S4, S3, S2, S1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
